mul_div_unit: RTL and testbench
===============================

Name: mul_div_unit

Overview:
- Iterative multiply/divide unit for the multi-cycle CPU; sits beside the combinational ALU in the execute stage and serves MULT/MULTU/DIV/DIVU.
- Generalises ALU arithmetic to a parametrised operand width and multi-cycle operation, with a start/busy/done handshake and HI/LO result registers.
- The control FSM issues Start, stalls while Busy is high, and reads Hi/Lo after Done.

Parameters:
WIDTH, 32, operand width in bits; legal values are 4..64, even only.
CNT_W, $clog2(WIDTH)+1, width of the iteration counter; derived, not to be overridden.

Ports:
clk  input  1  system clock; all state changes on the rising edge.
reset  input  1  asynchronous, active-low reset (reset=0 clears all state immediately).
Start  input  1  one-cycle request; sampled only when the unit is not Busy.
Op  input  1  0 = multiply, 1 = divide.
Sign  input  1  1 = signed two's-complement operands, 0 = unsigned.
In1  input  WIDTH  multiplicand / dividend.
In2  input  WIDTH  multiplier / divisor.
Busy  output  1  high while an operation is in progress.
Done  output  1  single-cycle pulse when Hi/Lo hold a new result.
DivZero  output  1  high alongside Done (and held with the result) when a divide had In2==0.
Hi  output  WIDTH  multiply: upper half of product; divide: remainder.
Lo  output  WIDTH  multiply: lower half of product; divide: quotient.

Behaviour:
- Reset values: Busy=0, Done=0, DivZero=0, Hi=0, Lo=0, FSM=IDLE, counter=0.
- FSM states are IDLE, CALC, FIX and DONE.
- IDLE/DONE: if Start=1, latch Op, Sign and the operand magnitudes (absolute value when Sign=1), record the result sign bits, set counter=WIDTH, and go to CALC. Otherwise DONE returns to IDLE.
- CALC: one radix-2 step per cycle, WIDTH cycles in total; go to FIX when the counter reaches 0.
  - Multiply uses shift-add into a 2*WIDTH accumulator.
  - Divide uses restoring shift-subtract.
- FIX: apply the sign correction, load Hi/Lo, then go to DONE.
- Busy=1 in CALC and FIX only.
- Done=1 exactly in the DONE cycle.
- Latency: Start sampled at edge N gives Done=1 in the cycle after edge N+WIDTH+1, i.e. WIDTH+2 edges after acceptance.
- Back-to-back operation: Start=1 during the DONE cycle is accepted. Done still pulses for that cycle and Busy rises on the next edge.
- Start while Busy is ignored; there is no queue, and operands must be re-presented.
- In1/In2/Op/Sign are don't-care after the accept edge.
- Hi/Lo/DivZero hold their value from FIX until the next FIX or reset; they are not cleared on accept.
- Signed multiply: {Hi,Lo} = full 2*WIDTH signed product. The most-negative operand is handled correctly (e.g. -2^(W-1) * -2^(W-1) = 2^(2W-2)).
- Signed divide:
  - Quotient truncates toward zero.
  - Remainder takes the sign of the dividend.
  - Invariant: In1 == Lo*In2 + Hi.
- Overflow case, Sign=1, In1 = -2^(W-1), In2 = -1: Lo = -2^(W-1), Hi = 0, no flag.
- Divide by zero (either Sign): full latency, Lo = all ones, Hi = In1 as latched, DivZero=1.
- DivZero=0 for all multiplies and for non-zero divides.
- Reset asserted mid-operation: abort immediately with all outputs at reset values. No Done pulse follows reset deassertion.

Test Plan:
- WIDTH=32, Op=0, Sign=0, In1=0xFFFFFFFF, In2=0xFFFFFFFF -> Done 34 edges after accept; Hi=0xFFFFFFFE, Lo=0x00000001; Busy high for exactly 33 cycles.
- WIDTH=32, Op=0, Sign=1, In1=-7, In2=6 -> Hi=0xFFFFFFFF, Lo=0xFFFFFFD6 (-42).
- WIDTH=32, Op=1, Sign=1, In1=-7, In2=2 -> Lo=0xFFFFFFFD (-3), Hi=0xFFFFFFFF (-1); Sign=0, In1=100, In2=7 -> Lo=14, Hi=2.
- Divide edge cases:
  - In2=0, In1=0x12345678 -> Lo=0xFFFFFFFF, Hi=0x12345678, DivZero=1.
  - Sign=1, In1=0x80000000, In2=0xFFFFFFFF -> Lo=0x80000000, Hi=0, DivZero=0.
- Handshake cases:
  - Start pulsed again while Busy -> ignored, with the result of the first op unchanged.
  - Start asserted in the Done cycle -> second op accepted, and its Done follows WIDTH+2 edges later.
  - reset=0 asserted mid-CALC -> Busy/Done/Hi/Lo are 0 at once, with no spurious Done afterwards.
- WIDTH=8 instance: signed -128 * -128 -> {Hi,Lo}=0x4000; unsigned 200/15 -> Lo=13, Hi=5, Done 10 edges after accept.

Source files
------------

// File: rtl/mul_div_unit_if.sv
// Request/result bundle between the execute-stage control FSM and mul_div_unit.
// Start is a request taken on a rising edge only while Busy is low; Done is a one-cycle valid for Hi/Lo/DivZero, with no backpressure.
interface mul_div_unit_if #(
  parameter int WIDTH = 32
);
  logic             Start;
  logic             Op;
  logic             Sign;
  logic [WIDTH-1:0] In1;
  logic [WIDTH-1:0] In2;
  logic             Busy;
  logic             Done;
  logic             DivZero;
  logic [WIDTH-1:0] Hi;
  logic [WIDTH-1:0] Lo;
  logic [1:0]       dbg_state;

  modport master (
    output Start, Op, Sign, In1, In2,
    input  Busy, Done, DivZero, Hi, Lo, dbg_state
  );

  modport slave (
    input  Start, Op, Sign, In1, In2,
    output Busy, Done, DivZero, Hi, Lo, dbg_state
  );
endinterface

// File: rtl/mul_div_unit.sv
// Iterative radix-2 multiply/divide: shift-add multiply and restoring divide on operand
// magnitudes, one sign-fixup cycle, then results land in the Hi/Lo registers.
module mul_div_unit #(
  parameter int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH) + 1
) (
  input logic           clk,
  input logic           reset,
  mul_div_unit_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic               op_q;
  logic               neg_res_q;
  logic               neg_rem_q;
  logic               div_zero_q;
  logic [WIDTH-1:0]   opnd_q;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;
  logic               dz_q;

  logic               accept;
  logic [WIDTH-1:0]   mag1;
  logic [WIDTH-1:0]   mag2;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     rem_sh;
  logic               rem_ge;
  logic [WIDTH-1:0]   rem_sub;
  logic [2*WIDTH-1:0] div_next;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  assign accept = bus.Start && (state == IDLE || state == DONE);
  assign mag1   = (bus.Sign && bus.In1[WIDTH-1]) ? -bus.In1 : bus.In1;
  assign mag2   = (bus.Sign && bus.In2[WIDTH-1]) ? -bus.In2 : bus.In2;

  // Multiply: multiplier sits in acc's low half and shifts out as the product shifts in.
  assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd_q} : '0);
  assign mul_next = {mul_sum, acc[WIDTH-1:1]};

  // Divide: remainder in the upper half, dividend bits leave the lower half as quotient bits enter.
  assign rem_sh   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
  assign rem_ge   = rem_sh >= {1'b0, opnd_q};
  assign rem_sub  = rem_sh[WIDTH-1:0] - opnd_q;
  assign div_next = {(rem_ge ? rem_sub : rem_sh[WIDTH-1:0]), acc[WIDTH-2:0], rem_ge};

  // A zero divisor leaves an all-ones quotient that must not be negated; the remainder
  // (dividend magnitude) regains the dividend's sign, which returns In1 unchanged.
  assign prod_fix = neg_res_q ? -acc : acc;
  assign quo_fix  = (neg_res_q && !div_zero_q) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
  assign rem_fix  = neg_rem_q ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (bus.Start) state_nxt = CALC;
      CALC:    if (cnt == CNT_W'(1)) state_nxt = FIX;
      FIX:     state_nxt = DONE;
      DONE:    state_nxt = bus.Start ? CALC : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt        <= '0;
      op_q       <= 1'b0;
      neg_res_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      div_zero_q <= 1'b0;
      opnd_q     <= '0;
      acc        <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      dz_q       <= 1'b0;
    end else begin
      if (accept) begin
        op_q       <= bus.Op;
        neg_res_q  <= bus.Sign && (bus.In1[WIDTH-1] ^ bus.In2[WIDTH-1]);
        neg_rem_q  <= bus.Sign && bus.In1[WIDTH-1];
        div_zero_q <= bus.Op && (bus.In2 == '0);
        opnd_q     <= bus.Op ? mag2 : mag1;
        acc        <= {{WIDTH{1'b0}}, (bus.Op ? mag1 : mag2)};
        cnt        <= CNT_W'(WIDTH);
      end else if (state == CALC) begin
        acc <= op_q ? div_next : mul_next;
        cnt <= cnt - CNT_W'(1);
      end
      if (state == FIX) begin
        hi_q <= op_q ? rem_fix : prod_fix[2*WIDTH-1:WIDTH];
        lo_q <= op_q ? quo_fix : prod_fix[WIDTH-1:0];
        dz_q <= op_q && div_zero_q;
      end
    end
  end

  assign bus.Busy      = (state == CALC) || (state == FIX);
  assign bus.Done      = (state == DONE);
  assign bus.DivZero   = dz_q;
  assign bus.Hi        = hi_q;
  assign bus.Lo        = lo_q;
  assign bus.dbg_state = state;

endmodule

// File: tb/tb_mul_div_unit.sv
// Bench for mul_div_unit: 32-bit and 8-bit instances, directed cases then random
// operations checked against an arithmetic reference model.
module tb_mul_div_unit;

  logic        clk;
  logic        reset;
  int          checks;
  int          fails;
  logic [63:0] exp_q[$];

  mul_div_unit_if #(.WIDTH(32)) b32 ();
  mul_div_unit_if #(.WIDTH(8))  b8 ();

  mul_div_unit #(.WIDTH(32)) dut32 (.clk(clk), .reset(reset), .bus(b32.slave));
  mul_div_unit #(.WIDTH(8))  dut8  (.clk(clk), .reset(reset), .bus(b8.slave));

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] rd_hi(input bit s);
    return s ? {56'd0, b8.Hi} : {32'd0, b32.Hi};
  endfunction
  function automatic logic [63:0] rd_lo(input bit s);
    return s ? {56'd0, b8.Lo} : {32'd0, b32.Lo};
  endfunction
  function automatic logic rd_busy(input bit s);
    return s ? b8.Busy : b32.Busy;
  endfunction
  function automatic logic rd_done(input bit s);
    return s ? b8.Done : b32.Done;
  endfunction
  function automatic logic rd_dz(input bit s);
    return s ? b8.DivZero : b32.DivZero;
  endfunction

  // driver tasks
  task automatic drive(input bit s, input bit st, input bit op, input bit sg,
                       input logic [63:0] a, input logic [63:0] b);
    if (s) begin
      b8.Start = st; b8.Op = op; b8.Sign = sg; b8.In1 = a[7:0]; b8.In2 = b[7:0];
    end else begin
      b32.Start = st; b32.Op = op; b32.Sign = sg; b32.In1 = a[31:0]; b32.In2 = b[31:0];
    end
  endtask

  task automatic set_start(input bit s, input bit v);
    if (s) b8.Start = v;
    else   b32.Start = v;
  endtask

  // reference model: plain signed/unsigned arithmetic at width w
  task automatic model(input int w, input bit op, input bit sg, input logic [63:0] a_in,
                       input logic [63:0] b_in, output logic [63:0] hi,
                       output logic [63:0] lo, output logic [63:0] dz);
    logic [63:0] mask;
    logic [63:0] a;
    logic [63:0] b;
    longint      sa, sb, t, p, q, r;
    mask = (64'd1 << w) - 64'd1;
    a = a_in & mask;
    b = b_in & mask;
    if (sg) begin
      t = a << (64 - w); sa = t >>> (64 - w);
      t = b << (64 - w); sb = t >>> (64 - w);
    end else begin
      sa = a;
      sb = b;
    end
    if (!op) begin
      p  = sa * sb;
      hi = (p >> w) & mask;
      lo = p & mask;
      dz = 64'd0;
    end else if (b == 64'd0) begin
      lo = mask;
      hi = a;
      dz = 64'd1;
    end else begin
      q  = sa / sb;
      r  = sa % sb;
      lo = q & mask;
      hi = r & mask;
      dz = 64'd0;
    end
  endtask

  task automatic launch(input bit s, input bit op, input bit sg,
                        input logic [63:0] a, input logic [63:0] b);
    logic [63:0] hi, lo, dz;
    model(s ? 8 : 32, op, sg, a, b, hi, lo, dz);
    exp_q.push_back(hi);
    exp_q.push_back(lo);
    exp_q.push_back(dz);
    drive(s, 1'b1, op, sg, a, b);
  endtask

  task automatic launch_k(input bit s, input bit op, input bit sg, input logic [63:0] a,
                          input logic [63:0] b, input logic [63:0] hi,
                          input logic [63:0] lo, input logic [63:0] dz);
    exp_q.push_back(hi);
    exp_q.push_back(lo);
    exp_q.push_back(dz);
    drive(s, 1'b1, op, sg, a, b);
  endtask

  // scoreboard: wait for Done, check latency, busy span and results; returns in the Done cycle
  task automatic complete(input string tag, input bit s, input int poke_at);
    int          w, edges, busy_n;
    logic [63:0] e_hi, e_lo, e_dz;
    w = s ? 8 : 32;
    @(posedge clk);
    edges = 1;
    @(negedge clk);
    drive(s, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          {$urandom, $urandom}, {$urandom, $urandom});
    busy_n = rd_busy(s) ? 1 : 0;
    while (!rd_done(s) && edges < 4 * w + 20) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      set_start(s, edges == poke_at);
      if (rd_busy(s)) busy_n++;
    end
    check({tag, " latency"}, 64'(edges), 64'(w + 2));
    check({tag, " busy cycles"}, 64'(busy_n), 64'(w + 1));
    check({tag, " done"}, 64'(rd_done(s)), 64'd1);
    e_hi = exp_q.pop_front();
    e_lo = exp_q.pop_front();
    e_dz = exp_q.pop_front();
    check({tag, " hi"}, rd_hi(s), e_hi);
    check({tag, " lo"}, rd_lo(s), e_lo);
    check({tag, " divzero"}, 64'(rd_dz(s)), e_dz);
  endtask

  task automatic gap(input string tag, input bit s);
    @(negedge clk);
    check({tag, " done pulse"}, 64'(rd_done(s)), 64'd0);
  endtask

  initial begin
    bit          op, sg;
    logic [63:0] a, b;
    int          spurious;
    checks = 0;
    fails  = 0;
    reset  = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 64'd0, 64'd0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 64'd0, 64'd0);
    #3 reset = 1'b0;
    repeat (2) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      check("reset busy", 64'(rd_busy(1'(s))), 64'd0);
      check("reset done", 64'(rd_done(1'(s))), 64'd0);
      check("reset divzero", 64'(rd_dz(1'(s))), 64'd0);
      check("reset hi", rd_hi(1'(s)), 64'd0);
      check("reset lo", rd_lo(1'(s)), 64'd0);
    end
    reset = 1'b1;
    @(negedge clk);

    // directed, 32-bit
    launch_k(0, 0, 0, 64'hFFFFFFFF, 64'hFFFFFFFF, 64'hFFFFFFFE, 64'h1, 0);
    complete("umul max", 0, 0);
    gap("umul max", 0);
    launch_k(0, 0, 1, 64'hFFFFFFF9, 64'd6, 64'hFFFFFFFF, 64'hFFFFFFD6, 0);
    complete("smul -7*6", 0, 0);
    gap("smul -7*6", 0);
    launch_k(0, 1, 1, 64'hFFFFFFF9, 64'd2, 64'hFFFFFFFF, 64'hFFFFFFFD, 0);
    complete("sdiv -7/2", 0, 0);
    gap("sdiv -7/2", 0);
    launch_k(0, 1, 0, 64'd100, 64'd7, 64'd2, 64'd14, 0);
    complete("udiv 100/7", 0, 0);
    gap("udiv 100/7", 0);
    launch_k(0, 1, 0, 64'h12345678, 64'd0, 64'h12345678, 64'hFFFFFFFF, 1);
    complete("div zero", 0, 0);
    gap("div zero", 0);
    check("divzero hold", 64'(rd_dz(0)), 64'd1);
    launch_k(0, 1, 1, 64'hF0000001, 64'd0, 64'hF0000001, 64'hFFFFFFFF, 1);
    complete("sdiv zero", 0, 0);
    gap("sdiv zero", 0);
    launch_k(0, 1, 1, 64'h80000000, 64'hFFFFFFFF, 64'd0, 64'h80000000, 0);
    complete("sdiv overflow", 0, 0);
    gap("sdiv overflow", 0);
    launch_k(0, 0, 1, 64'h80000000, 64'h80000000, 64'h40000000, 64'd0, 0);
    complete("smul minneg", 0, 0);
    gap("smul minneg", 0);

    // Start while busy must be ignored
    launch_k(0, 1, 0, 64'd100, 64'd7, 64'd2, 64'd14, 0);
    complete("start while busy", 0, 4);
    gap("start while busy", 0);

    // back-to-back: second Start issued in the Done cycle
    launch_k(0, 0, 0, 64'd3, 64'd5, 64'd0, 64'd15, 0);
    complete("b2b first", 0, 0);
    launch_k(0, 1, 1, 64'hFFFFFF9C, 64'd7, 64'hFFFFFFFE, 64'hFFFFFFF2, 0);
    complete("b2b second", 0, 0);
    gap("b2b second", 0);

    // directed, 8-bit
    launch_k(1, 0, 1, 64'h80, 64'h80, 64'h40, 64'h00, 0);
    complete("w8 smul minneg", 1, 0);
    gap("w8 smul minneg", 1);
    launch_k(1, 1, 0, 64'd200, 64'd15, 64'd5, 64'd13, 0);
    complete("w8 udiv 200/15", 1, 0);
    gap("w8 udiv 200/15", 1);

    // random, both widths
    for (int i = 0; i < 70; i++) begin
      bit s;
      s  = (i >= 40);
      op = 1'($urandom_range(0, 1));
      sg = 1'($urandom_range(0, 1));
      a  = {$urandom, $urandom};
      b  = {$urandom, $urandom};
      case ($urandom_range(0, 7))
        0: b = 64'd0;
        1: begin a = s ? 64'h80 : 64'h80000000; b = 64'hFFFFFFFFFFFFFFFF; end
        2: a = s ? 64'h80 : 64'h80000000;
        3: b = 64'(1 + $urandom_range(0, 5));
        default: ;
      endcase
      launch(s, op, sg, a, b);
      complete(s ? "rand w8" : "rand w32", s, 0);
      if ($urandom_range(0, 1) == 1) gap(s ? "rand w8" : "rand w32", s);
    end
    gap("rand end", 1);

    // reset in the middle of CALC
    launch(0, 0, 0, 64'h0000FFFF, 64'h00FF00FF);
    @(posedge clk);
    @(negedge clk);
    set_start(0, 1'b0);
    repeat (4) @(negedge clk);
    reset = 1'b0;
    #1;
    check("midreset busy", 64'(rd_busy(0)), 64'd0);
    check("midreset done", 64'(rd_done(0)), 64'd0);
    check("midreset hi", rd_hi(0), 64'd0);
    check("midreset lo", rd_lo(0), 64'd0);
    check("midreset divzero", 64'(rd_dz(0)), 64'd0);
    exp_q.delete();
    @(negedge clk);
    reset = 1'b1;
    spurious = 0;
    repeat (80) begin
      @(negedge clk);
      if (rd_done(0) || rd_busy(0)) spurious++;
    end
    check("no done after reset", 64'(spurious), 64'd0);
    check("hi after reset", rd_hi(0), 64'd0);

    launch(0, 1, 1, 64'h7FFFFFFF, 64'hFFFFFFFD);
    complete("after reset", 0, 0);
    gap("after reset", 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
